// File: rtl/axi_regs_pkg.sv
// axi_regs_pkg
// Shared constants and types for the AXI4-Lite register file:
//   - bus widths (32-bit data, 5-bit byte address, 4 byte strobes)
//   - register indices REG_CTRL0..REG_CTRL5 (RW), REG_STATUS, REG_ID (RO)
//   - write/read response codes
//   - default ID constant
//   - the captured write request and a byte-lane merge helper
package axi_regs_pkg;

  localparam int AXI_DATA_W  = 32;
  localparam int AXI_ADDR_W  = 5;
  localparam int AXI_STRB_W  = AXI_DATA_W / 8;
  localparam int NUM_RW_REGS = 6;

  typedef logic [2:0]            reg_idx_t;
  typedef logic [AXI_DATA_W-1:0] word_t;
  typedef logic [AXI_STRB_W-1:0] strb_t;

  localparam reg_idx_t REG_CTRL0  = 3'd0;
  localparam reg_idx_t REG_CTRL1  = 3'd1;
  localparam reg_idx_t REG_CTRL2  = 3'd2;
  localparam reg_idx_t REG_CTRL3  = 3'd3;
  localparam reg_idx_t REG_CTRL4  = 3'd4;
  localparam reg_idx_t REG_CTRL5  = 3'd5;
  localparam reg_idx_t REG_STATUS = 3'd6;
  localparam reg_idx_t REG_ID     = 3'd7;

  localparam word_t ID_VALUE_DEFAULT = 32'hA11E_0001;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  // One complete write request, presented when both AW and W are held.
  typedef struct packed {
    reg_idx_t idx;
    word_t    data;
    strb_t    strb;
  } wr_req_t;

  function automatic logic is_rw_reg(reg_idx_t idx);
    return idx <= REG_CTRL5;
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic word_t merge_bytes(word_t old_w, word_t new_w, strb_t strb);
    word_t res;
    res = old_w;
    for (int i = 0; i < AXI_STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_wr_capture.sv
// axi_lite_wr_capture
// Independent AW and W capture slots for the AXI4-Lite write path.
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   aw_idx/aw_valid/aw_ready : word index from the write address channel
//   w_data/w_strb/w_valid/w_ready : write data channel
//   resp_busy             : a write response is outstanding; blocks new captures
//   commit                : high for the cycle in which both slots are held;
//                           the top commits on the edge that ends this cycle
//   commit_req            : held address, data and strobes
module axi_lite_wr_capture
  import axi_regs_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  reg_idx_t aw_idx,
  input  logic     aw_valid,
  output logic     aw_ready,
  input  word_t    w_data,
  input  strb_t    w_strb,
  input  logic     w_valid,
  output logic     w_ready,
  input  logic     resp_busy,
  output logic     commit,
  output wr_req_t  commit_req
);

  logic     aw_held_q, aw_held_d;
  logic     w_held_q,  w_held_d;
  reg_idx_t aw_idx_q,  aw_idx_d;
  word_t    w_data_q,  w_data_d;
  strb_t    w_strb_q,  w_strb_d;

  assign aw_ready   = !rst && !aw_held_q && !resp_busy;
  assign w_ready    = !rst && !w_held_q  && !resp_busy;
  assign commit     = aw_held_q && w_held_q;
  assign commit_req = '{idx: aw_idx_q, data: w_data_q, strb: w_strb_q};

  always_comb begin
    // NOTE: every _d gets its current value first, so no path can infer a latch.
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    // A slot's ready is low while it is held, so a capture never collides
    // with the commit that empties it.
    if (aw_valid && aw_ready) begin
      aw_held_d = 1'b1;
      aw_idx_d  = aw_idx;
    end
    if (w_valid && w_ready) begin
      w_held_d = 1'b1;
      w_data_d = w_data;
      w_strb_d = w_strb;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
    end
  end

  // Payload is only looked at while its held flag is set.
  always_ff @(posedge clk) begin
    aw_idx_q <= aw_idx_d;
    w_data_q <= w_data_d;
    w_strb_q <= w_strb_d;
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
// AXI4-Lite slave with eight 32-bit registers at byte addresses 0x00..0x1C.
//   s0_axi_aclk / s0_axi_areset : clock, synchronous active-high reset
//   s0_axi_aw* / w* / b*        : write address, data and response channels
//   s0_axi_ar* / r*             : read address and data channels
//   reg_out   : registers 0..5 (RW), reg n at [32n+31:32n]
//   wr_pulse  : bit n high for one cycle after reg n is written
//   status_in : live value returned by reads of register 6
// Register 7 returns C_ID_VALUE. Writes to 6 and 7 answer SLVERR.
module axi_lite_regfile
  import axi_regs_pkg::*;
#(
  parameter int          C_S0_AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int          C_S0_AXI_ADDR_WIDTH = AXI_ADDR_W,
  parameter logic [31:0] C_ID_VALUE          = ID_VALUE_DEFAULT
) (
  input  logic                               s0_axi_aclk,
  input  logic                               s0_axi_areset,
  input  logic [C_S0_AXI_ADDR_WIDTH-1:0]     s0_axi_awaddr,
  input  logic [2:0]                         s0_axi_awprot,
  input  logic                               s0_axi_awvalid,
  output logic                               s0_axi_awready,
  input  logic [C_S0_AXI_DATA_WIDTH-1:0]     s0_axi_wdata,
  input  logic [C_S0_AXI_DATA_WIDTH/8-1:0]   s0_axi_wstrb,
  input  logic                               s0_axi_wvalid,
  output logic                               s0_axi_wready,
  output logic [1:0]                         s0_axi_bresp,
  output logic                               s0_axi_bvalid,
  input  logic                               s0_axi_bready,
  input  logic [C_S0_AXI_ADDR_WIDTH-1:0]     s0_axi_araddr,
  input  logic [2:0]                         s0_axi_arprot,
  input  logic                               s0_axi_arvalid,
  output logic                               s0_axi_arready,
  output logic [C_S0_AXI_DATA_WIDTH-1:0]     s0_axi_rdata,
  output logic [1:0]                         s0_axi_rresp,
  output logic                               s0_axi_rvalid,
  input  logic                               s0_axi_rready,
  output logic [NUM_RW_REGS*AXI_DATA_W-1:0]  reg_out,
  output logic [NUM_RW_REGS-1:0]             wr_pulse,
  input  logic [AXI_DATA_W-1:0]              status_in
);

  logic clk;
  logic rst;
  assign clk = s0_axi_aclk;
  assign rst = s0_axi_areset;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s0_axi_awprot, s0_axi_arprot,
                           s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

  // ---------------------------------------------------------------- write side
  logic    commit;
  wr_req_t commit_req;

  word_t                  regs_q [NUM_RW_REGS];
  word_t                  regs_d [NUM_RW_REGS];
  logic [NUM_RW_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic                   bvalid_q, bvalid_d;
  axi_resp_e              bresp_q, bresp_d;

  axi_lite_wr_capture u_wr_capture (
    .clk        (clk),
    .rst        (rst),
    .aw_idx     (s0_axi_awaddr[4:2]),
    .aw_valid   (s0_axi_awvalid),
    .aw_ready   (s0_axi_awready),
    .w_data     (s0_axi_wdata),
    .w_strb     (s0_axi_wstrb),
    .w_valid    (s0_axi_wvalid),
    .w_ready    (s0_axi_wready),
    .resp_busy  (bvalid_q),
    .commit     (commit),
    .commit_req (commit_req)
  );

  // ----------------------------------------------------------------- read side
  reg_idx_t rd_idx;
  word_t    rd_word;
  logic     rvalid_q, rvalid_d;
  word_t    rdata_q,  rdata_d;

  assign rd_idx         = s0_axi_araddr[4:2];
  assign s0_axi_arready = !rst && !rvalid_q;

  // Reads see regs_q, so a read on the commit edge returns the old value.
  always_comb begin
    case (rd_idx)
      REG_STATUS: rd_word = status_in;
      REG_ID:     rd_word = C_ID_VALUE;
      default:    rd_word = regs_q[rd_idx];
    endcase
  end

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;

    // bvalid is low whenever a commit is possible, so the two branches
    // can never both apply.
    if (commit) begin
      bvalid_d = 1'b1;
      if (is_rw_reg(commit_req.idx)) begin
        regs_d[commit_req.idx]     = merge_bytes(regs_q[commit_req.idx],
                                                 commit_req.data, commit_req.strb);
        wr_pulse_d[commit_req.idx] = 1'b1;
        bresp_d                    = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else if (bvalid_q && s0_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (rvalid_q) begin
      if (s0_axi_rready) rvalid_d = 1'b0;
    end else if (s0_axi_arvalid && s0_axi_arready) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset because reg_out must read zero after
      // reset; an array that is only read after being written could skip this.
      for (int i = 0; i < NUM_RW_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign s0_axi_bvalid = bvalid_q;
  assign s0_axi_bresp  = bresp_q;
  assign s0_axi_rvalid = rvalid_q;
  assign s0_axi_rdata  = rdata_q;
  assign s0_axi_rresp  = RESP_OKAY;
  assign wr_pulse      = wr_pulse_q;

  always_comb begin
    for (int i = 0; i < NUM_RW_REGS; i++) reg_out[32*i +: 32] = regs_q[i];
  end

endmodule
